// File: rtl/sdram_arbiter.sv
// Two-engine SDRAM bus arbiter with periodic auto-refresh insertion.
// Optional macro SDRAM_ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests (default: write wins).
`ifndef SDRAM_CMD_NOP
`define SDRAM_CMD_NOP 3'b111
`endif
`ifndef SDRAM_CMD_AR
`define SDRAM_CMD_AR 3'b001
`endif

module sdram_arbiter #(
   parameter int REFRESH_PERIOD = 1560,
   parameter int T_RFC          = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sdram_ready,
   input  logic        wr_request,
   input  logic        rd_request,
   input  logic        wr_idle,
   input  logic        rd_idle,
   input  logic [2:0]  wr_command,
   input  logic [2:0]  rd_command,
   input  logic [11:0] wr_address,
   input  logic [11:0] rd_address,
   input  logic [1:0]  wr_bank,
   input  logic [1:0]  rd_bank,
   output logic        wr_enable,
   output logic        rd_enable,
   output logic        auto_refresh,
   output logic [2:0]  command,
   output logic [11:0] address,
   output logic [1:0]  bank,
   output logic        missed_refresh
);

   localparam int TW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
   localparam int DW = (T_RFC > 1) ? $clog2(T_RFC) : 1;
   localparam logic [TW-1:0] TIMER_RELOAD = TW'(REFRESH_PERIOD - 1);
   localparam logic [DW-1:0] DLY_LOAD     = DW'(T_RFC - 1);

   typedef enum logic [2:0] {IDLE, GRANT_WR, GRANT_RD, REFRESH, REFRESH_WAIT} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_WR, OWN_RD} owner_t;

   state_t        state_q, state_d;
   owner_t        owner_q, owner_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [DW-1:0] dly_q, dly_d;
   logic          pending_q, pending_d;
   logic          missed_q, missed_d;
   logic          wr_en_q, wr_en_d;
   logic          rd_en_q, rd_en_d;
   logic          expire;
   logic          start_ref;
   logic          rr_pick_rd;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   logic last_rd_q, last_rd_d;

   // Remember who was granted last; a tie goes to the other requester.
   always_comb begin
      last_rd_d = last_rd_q;
      if (state_d == GRANT_WR) last_rd_d = 1'b0;
      else if (state_d == GRANT_RD) last_rd_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) last_rd_q <= 1'b1;
      else     last_rd_q <= last_rd_d;
   end

   assign rr_pick_rd = ~last_rd_q;
`else
   assign rr_pick_rd = 1'b0;
`endif

   always_comb begin
      expire  = sdram_ready && (timer_q == '0);
      timer_d = (!sdram_ready || expire) ? TIMER_RELOAD : timer_q - TW'(1);
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      dly_d     = dly_q;
      wr_en_d   = wr_en_q;
      rd_en_d   = rd_en_q;
      start_ref = 1'b0;
      case (state_q)
         IDLE: begin
            if (sdram_ready) begin
               if (pending_q) begin
                  state_d   = REFRESH;
                  owner_d   = OWN_NONE;
                  start_ref = 1'b1;
               end else if (wr_request && !(rd_request && rr_pick_rd)) begin
                  state_d = GRANT_WR;
                  wr_en_d = 1'b1;
               end else if (rd_request) begin
                  state_d = GRANT_RD;
                  rd_en_d = 1'b1;
               end
            end
         end
         GRANT_WR: begin
            if (wr_idle && pending_q) begin
               state_d   = REFRESH;
               owner_d   = OWN_WR;
               start_ref = 1'b1;
            end else if (wr_idle && !wr_request) begin
               state_d = IDLE;
               wr_en_d = 1'b0;
            end
         end
         GRANT_RD: begin
            if (rd_idle && pending_q) begin
               state_d   = REFRESH;
               owner_d   = OWN_RD;
               start_ref = 1'b1;
            end else if (rd_idle && !rd_request) begin
               state_d = IDLE;
               rd_en_d = 1'b0;
            end
         end
         REFRESH: begin
            state_d = REFRESH_WAIT;
            dly_d   = DLY_LOAD;
         end
         REFRESH_WAIT: begin
            if (dly_q != '0) begin
               dly_d = dly_q - DW'(1);
            end else begin
               owner_d = OWN_NONE;
               // The interrupted owner keeps its enable through the refresh and resumes directly.
               if (owner_q == OWN_WR && wr_request) begin
                  state_d = GRANT_WR;
               end else if (owner_q == OWN_RD && rd_request) begin
                  state_d = GRANT_RD;
               end else begin
                  state_d = IDLE;
                  wr_en_d = 1'b0;
                  rd_en_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Expiry wins over the clear so a refresh due in the AR cycle itself is not lost.
   always_comb begin
      pending_d = pending_q;
      missed_d  = missed_q;
      if (start_ref) pending_d = 1'b0;
      if (expire) begin
         pending_d = 1'b1;
         if (pending_q) missed_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= OWN_NONE;
         timer_q   <= TIMER_RELOAD;
         dly_q     <= '0;
         pending_q <= 1'b0;
         missed_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         timer_q   <= timer_d;
         dly_q     <= dly_d;
         pending_q <= pending_d;
         missed_q  <= missed_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
      end
   end

   always_comb begin
      command = `SDRAM_CMD_NOP;
      address = '0;
      bank    = '0;
      case (state_q)
         GRANT_WR: begin
            command = wr_command;
            address = wr_address;
            bank    = wr_bank;
         end
         GRANT_RD: begin
            command = rd_command;
            address = rd_address;
            bank    = rd_bank;
         end
         REFRESH: command = `SDRAM_CMD_AR;
         default: ;
      endcase
   end

   assign wr_enable      = wr_en_q;
   assign rd_enable      = rd_en_q;
   assign auto_refresh   = pending_q;
   assign missed_refresh = missed_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_sdram_arbiter;

   localparam int P = 16;
   localparam int T = 7;
   localparam logic [2:0] NOP = 3'b111;
   localparam logic [2:0] AR  = 3'b001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sdram_ready = 1'b0;
   logic        wr_request = 1'b0, rd_request = 1'b0;
   logic        wr_idle = 1'b1, rd_idle = 1'b1;
   logic [2:0]  wr_command = 3'b000, rd_command = 3'b000;
   logic [11:0] wr_address = '0, rd_address = '0;
   logic [1:0]  wr_bank = '0, rd_bank = '0;
   logic        wr_enable, rd_enable, auto_refresh, missed_refresh;
   logic [2:0]  command;
   logic [11:0] address;
   logic [1:0]  bank;

   int tests = 0;
   int fails = 0;

   // Reference model: who holds the bus (0 none, 1 write, 2 read), cycles of refresh left,
   // ready clocks elapsed in the current refresh period.
   int m_own = 0, m_ref = 0, m_ticks = 0;
   bit m_pend = 0, m_missed = 0, m_last_rd = 1;

   sdram_arbiter #(.REFRESH_PERIOD(P), .T_RFC(T)) dut (
      .clk(clk), .rst(rst), .sdram_ready(sdram_ready),
      .wr_request(wr_request), .rd_request(rd_request),
      .wr_idle(wr_idle), .rd_idle(rd_idle),
      .wr_command(wr_command), .rd_command(rd_command),
      .wr_address(wr_address), .rd_address(rd_address),
      .wr_bank(wr_bank), .rd_bank(rd_bank),
      .wr_enable(wr_enable), .rd_enable(rd_enable),
      .auto_refresh(auto_refresh),
      .command(command), .address(address), .bank(bank),
      .missed_refresh(missed_refresh)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit expiry, start, old_pend;
      int req, idl;
      if (rst) begin
         m_own = 0; m_ref = 0; m_ticks = 0; m_pend = 0; m_missed = 0; m_last_rd = 1;
         return;
      end
      expiry  = sdram_ready && (m_ticks == P - 1);
      m_ticks = (!sdram_ready || expiry) ? 0 : m_ticks + 1;
      start   = 0;
      if (m_ref > 1) begin
         m_ref--;
      end else if (m_ref == 1) begin
         m_ref = 0;
         if (!((m_own == 1 && wr_request) || (m_own == 2 && rd_request))) m_own = 0;
      end else if (m_own != 0) begin
         idl = (m_own == 1) ? int'(wr_idle) : int'(rd_idle);
         req = (m_own == 1) ? int'(wr_request) : int'(rd_request);
         if (idl == 1 && m_pend) start = 1;
         else if (idl == 1 && req == 0) m_own = 0;
      end else if (sdram_ready) begin
         if (m_pend) start = 1;
         else if (wr_request && rd_request) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            m_own = m_last_rd ? 1 : 2;
`else
            m_own = 1;
`endif
         end else if (wr_request) m_own = 1;
         else if (rd_request) m_own = 2;
      end
      if (start) m_ref = T + 1;
      if (m_own != 0 && m_ref == 0) m_last_rd = (m_own == 2);
      old_pend = m_pend;
      if (start) m_pend = 0;
      if (expiry) begin
         if (old_pend) m_missed = 1;
         m_pend = 1;
      end
   endtask

   task automatic check_outputs();
      logic [2:0]  ec;
      logic [11:0] ea;
      logic [1:0]  eb;
      ec = NOP; ea = '0; eb = '0;
      if (m_ref == T + 1) ec = AR;
      else if (m_ref == 0 && m_own == 1) begin ec = wr_command; ea = wr_address; eb = wr_bank; end
      else if (m_ref == 0 && m_own == 2) begin ec = rd_command; ea = rd_address; eb = rd_bank; end
      chk("command", 32'(command), 32'(ec));
      chk("address", 32'(address), 32'(ea));
      chk("bank", 32'(bank), 32'(eb));
      chk("wr_enable", 32'(wr_enable), 32'(m_own == 1));
      chk("rd_enable", 32'(rd_enable), 32'(m_own == 2));
      chk("auto_refresh", 32'(auto_refresh), 32'(m_pend));
      chk("missed_refresh", 32'(missed_refresh), 32'(m_missed));
      chk("enables_exclusive", 32'(wr_enable & rd_enable), 32'(0));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int ar_cyc[$];
      int grants[$];
      int held, n;
      logic pw, pr;

      // Reset state
      do_reset();
      chk("rst_command", 32'(command), 32'(NOP));
      chk("rst_wr_enable", 32'(wr_enable), 32'(0));
      chk("rst_rd_enable", 32'(rd_enable), 32'(0));
      chk("rst_auto_refresh", 32'(auto_refresh), 32'(0));
      chk("rst_missed", 32'(missed_refresh), 32'(0));

      // Idle bus: AR every P clocks, one clock wide, T NOP clocks after
      sdram_ready = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if (command === AR) ar_cyc.push_back(i);
      end
      chk("ar_count", 32'(ar_cyc.size()), 32'(3));
      for (int i = 1; i < ar_cyc.size(); i++) chk("ar_spacing", 32'(ar_cyc[i] - ar_cyc[i-1]), 32'(P));
      chk("idle_missed", 32'(missed_refresh), 32'(0));

      // Long write burst holds the grant across two expiries
      do_reset();
      wr_request = 1'b1; wr_idle = 1'b0; wr_command = 3'b100; wr_address = 12'h5a3; wr_bank = 2'd2;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("burst_wr_enable", 32'(wr_enable), 32'(1));
      end
      chk("burst_missed", 32'(missed_refresh), 32'(1));
      wr_idle = 1'b1;
      tick();
      chk("burst_ar", 32'(command), 32'(AR));
      chk("burst_ar_wr_enable", 32'(wr_enable), 32'(1));
      for (int i = 0; i < T; i++) begin
         tick();
         chk("burst_rfc_nop", 32'(command), 32'(NOP));
         chk("burst_rfc_wr_enable", 32'(wr_enable), 32'(1));
      end
      tick();
      chk("burst_regrant_cmd", 32'(command), 32'(3'b100));
      chk("burst_regrant_addr", 32'(address), 32'(12'h5a3));

      // Read grant drives rd_* onto the bus with zero latency
      wr_request = 1'b0;
      do_reset();
      rd_request = 1'b1; rd_command = 3'b101; rd_address = 12'h0c7; rd_bank = 2'd1;
      tick();
      rd_command = 3'b101; wr_command = 3'b100;
      #1;
      chk("rd_cmd", 32'(command), 32'(3'b101));
      chk("rd_addr", 32'(address), 32'(12'h0c7));
      chk("rd_wr_enable", 32'(wr_enable), 32'(0));
      chk("rd_rd_enable", 32'(rd_enable), 32'(1));
      rd_request = 1'b0;

      // Simultaneous requests: grant order
      do_reset();
      wr_request = 1'b1; rd_request = 1'b1; wr_idle = 1'b1; rd_idle = 1'b1;
      pw = 1'b0; pr = 1'b0; held = 0;
      for (int i = 0; i < 150 && grants.size() < 4; i++) begin
         tick();
         if (wr_enable && !pw) grants.push_back(1);
         if (rd_enable && !pr) grants.push_back(2);
         pw = wr_enable; pr = rd_enable;
         wr_request = 1'b1; rd_request = 1'b1;
         if (wr_enable || rd_enable) begin
            held++;
            if (held == 5) begin
               if (wr_enable) wr_request = 1'b0; else rd_request = 1'b0;
               held = 0;
            end
         end else held = 0;
      end
      chk("grant_count", 32'(grants.size()), 32'(4));
      for (int i = 0; i < grants.size(); i++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
         chk("grant_order", 32'(grants[i]), 32'((i % 2 == 0) ? 1 : 2));
`else
         chk("grant_order", 32'(grants[i]), 32'(1));
`endif
      end
      wr_request = 1'b0; rd_request = 1'b0;

      // Reset during REFRESH_WAIT
      do_reset();
      n = 0;
      while (command !== AR && n < 40) begin tick(); n++; end
      chk("pre_rst_ar_seen", 32'(command), 32'(AR));
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("wait_rst_command", 32'(command), 32'(NOP));
      chk("wait_rst_enables", 32'({wr_enable, rd_enable}), 32'(0));
      chk("wait_rst_auto_refresh", 32'(auto_refresh), 32'(0));
      rst = 1'b0;
      n = 0;
      while (command !== AR && n < 60) begin tick(); n++; end
      // n counts edges after the reset edge; the first of them is where rst is first sampled low.
      chk("ar_after_release", 32'(n - 1), 32'(P));

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 399) == 0);
         sdram_ready = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 5) == 0) wr_request = ~wr_request;
         if ($urandom_range(0, 5) == 0) rd_request = ~rd_request;
         wr_idle    = ($urandom_range(0, 2) != 0);
         rd_idle    = ($urandom_range(0, 2) != 0);
         wr_command = 3'($urandom);
         rd_command = 3'($urandom);
         wr_address = 12'($urandom);
         rd_address = 12'($urandom);
         wr_bank    = 2'($urandom);
         rd_bank    = 2'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_PERIOD, default 1560, clocks between auto-refresh requests.
REQ-002 SHALL have parameter T_RFC, default 7, clocks the bus is held NOP after an AUTO REFRESH command.
REQ-003 SHALL have ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- sdram_ready  in  1  SDRAM init complete.
- wr_request, rd_request  in  1 each  requester wants the SDRAM.
- wr_idle, rd_idle  in  1 each  engine idle (delay 0, IDLE or WAIT state).
- wr_command, rd_command  in  3 each  engine SDRAM command.
- wr_address, rd_address  in  12 each  engine SDRAM address.
- wr_bank, rd_bank  in  2 each  engine SDRAM bank.
- wr_enable, rd_enable  out  1 each  grant/enable to the engine.
- auto_refresh  out  1  refresh pending, to both engines.
- command  out  3  SDRAM command bus.
- address  out  12  SDRAM address bus.
- bank  out  2  SDRAM bank bus.
- missed_refresh  out  1  sticky: refresh period expired while one was still pending.

Function
REQ-004 States SHALL be IDLE, GRANT_WR, GRANT_RD, REFRESH, REFRESH_WAIT.
REQ-005 Refresh timer SHALL count down from REFRESH_PERIOD-1 each clock while sdram_ready=1; at 0: set refresh_pending, reload. Held at reload value while sdram_ready=0.
REQ-006 Timer expiry while refresh_pending=1 SHALL set missed_refresh; pending stays 1 (no queueing).
REQ-007 auto_refresh SHALL equal refresh_pending; pending SHALL clear in the cycle the AR command is driven.
REQ-008 Bus mux SHALL be combinational, zero latency: GRANT_WR -> wr_*, GRANT_RD -> rd_*; IDLE/REFRESH_WAIT -> NOP, address 0, bank 0; REFRESH -> `SDRAM_CMD_AR, address 0, bank 0.
REQ-009 IDLE: sdram_ready=0 -> stay. Else refresh_pending -> REFRESH. Else a single requester -> its GRANT state, enable asserted from next clock. Both requesting -> priority per REQ-015.
REQ-010 GRANT_x: enable held 1. Leave only when x_idle=1 and (refresh_pending=1 or x_request=0). Pending -> REFRESH, enable stays 1, owner saved. Request dropped -> IDLE, enable 0 next clock.
REQ-011 Request deasserted mid-burst (x_idle=0) SHALL NOT revoke the grant until x_idle=1.
REQ-012 REFRESH SHALL last exactly one clock, load delay counter with T_RFC-1, then go to REFRESH_WAIT.
REQ-013 REFRESH_WAIT: NOP until counter reaches 0. Then saved owner still requesting -> its GRANT state; else enable 0, go IDLE.
REQ-014 wr_enable and rd_enable SHALL never both be 1. No engine command reaches the bus outside its GRANT state.

Reset
REQ-016 rst=1 SHALL, at the next clk edge and regardless of state, force IDLE; enables 0; refresh_pending 0; missed_refresh 0; timer = REFRESH_PERIOD-1; delay counter 0; saved owner none; last-served = read. Bus outputs NOP/0/0 from that edge.

Configuration
REQ-015 Macro SDRAM_ARB_ROUND_ROBIN_EN: defined -> on simultaneous requests in IDLE, grant the requester not served last (after reset: write). Undefined -> write always wins; read granted only when wr_request=0.

Verification
REQ-017 REFRESH_PERIOD=16, sdram_ready=1, no requests -> AR on command every 16 clocks, exactly 1 clock wide, NOP for 7 clocks after; missed_refresh=0.
REQ-018 wr_request held with wr_idle=0 for 40 clocks, REFRESH_PERIOD=16 -> grant kept; missed_refresh=1 after 2nd expiry; when wr_idle=1, AR one clock later, wr_enable held 1; GRANT_WR re-entered after 7 NOP clocks.
REQ-019 wr_request and rd_request both 1 from reset, each released after 5 idle clocks -> with macro: grants W,R,W,R; without macro: W repeatedly, R never granted.
REQ-020 rd granted with rd_command=READ(3'b101) -> command equals rd_command in the same cycle; wr_command ignored; wr_enable=0.
REQ-021 rst asserted during REFRESH_WAIT -> next clock: command NOP, enables 0, auto_refresh 0; first AR exactly REFRESH_PERIOD clocks after rst release.
